// File: rtl/ahb_avalon_extmem_bridge.sv
// AHB-Lite subordinate that turns each EXT_MEM beat into one Avalon-MM read or write.
// Latency: write ready at t+3, read ready at t+2+L (L = Avalon read latency), plus waitrequest stalls.
// Backpressure: HREADYExt is held low while Avalon waitrequest stalls or read data is outstanding.
module ahb_avalon_extmem_bridge #(
    parameter int              AHBW          = 32,
    parameter int              PA_BITS       = 32,
    parameter logic [63:0]     EXT_MEM_BASE  = 64'h2000_0000,
    parameter logic [63:0]     EXT_MEM_RANGE = 64'h0E00_0000,
    parameter int              AVL_ADDR_BITS = 28
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     HSELExt,
    input  logic [PA_BITS-1:0]       HADDR,
    input  logic [1:0]               HTRANS,
    input  logic                     HWRITE,
    input  logic [2:0]               HSIZE,
    input  logic [2:0]               HBURST,
    input  logic                     HREADY,
    input  logic [31:0]              HWDATA,
    input  logic [3:0]               HWSTRB,
    output logic                     HREADYExt,
    output logic                     HRESPExt,
    output logic [31:0]              HRDATAExt,
    output logic [AVL_ADDR_BITS-1:0] avm_address,
    output logic                     avm_read,
    output logic                     avm_write,
    output logic [31:0]              avm_writedata,
    output logic [3:0]               avm_byteenable,
    input  logic                     avm_waitrequest,
    input  logic [31:0]              avm_readdata,
    input  logic                     avm_readdatavalid
);

    // Elaboration-time sanity terms; never read by logic.
    localparam bit cfg_unused_ok = (AHBW == 32) &&
                                   (EXT_MEM_RANGE < (64'd1 << AVL_ADDR_BITS));

    typedef enum logic [2:0] {
        IDLE, WR_DATA, WR_REQ, RD_REQ, RD_WAIT, DONE, ERR1, ERR2
    } state_t;

    state_t               state;
    logic                 accept;
    logic                 size_err;
    logic [3:0]           rd_be;
    logic [PA_BITS-1:0]   offset;

    assign accept = HSELExt & HTRANS[1] & HREADY;
    assign offset = HADDR - EXT_MEM_BASE[PA_BITS-1:0];

    assign size_err = (HSIZE > 3'd2) ||
                      ((HSIZE == 3'd1) && HADDR[0]) ||
                      ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));

    always_comb begin
        rd_be = 4'b1111;
        case (HSIZE)
            3'd0:    rd_be = 4'b0001 << HADDR[1:0];
            3'd1:    rd_be = 4'b0011 << HADDR[1:0];
            default: rd_be = 4'b1111;
        endcase
    end

    // Bursts are treated as independent SINGLE beats; the upper offset bits fall outside the window.
    logic unused_ok;
    assign unused_ok = &{1'b0, HBURST, HTRANS[0], offset[PA_BITS-1:AVL_ADDR_BITS],
                         offset[1:0], cfg_unused_ok};

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            HREADYExt      <= 1'b1;
            HRESPExt       <= 1'b0;
            HRDATAExt      <= '0;
            avm_address    <= '0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_writedata  <= '0;
            avm_byteenable <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERR2: begin
                    state     <= IDLE;
                    HREADYExt <= 1'b1;
                    HRESPExt  <= 1'b0;
                    if (accept) begin
                        HREADYExt <= 1'b0;
                        if (size_err) begin
                            state    <= ERR1;
                            HRESPExt <= 1'b1;
                        end else if (HWRITE) begin
                            state       <= WR_DATA;
                            avm_address <= {offset[AVL_ADDR_BITS-1:2], 2'b00};
                        end else begin
                            state          <= RD_REQ;
                            avm_address    <= {offset[AVL_ADDR_BITS-1:2], 2'b00};
                            avm_byteenable <= rd_be;
                            avm_read       <= 1'b1;
                        end
                    end
                end
                WR_DATA: begin
                    state          <= WR_REQ;
                    avm_writedata  <= HWDATA;
                    avm_byteenable <= HWSTRB;
                    avm_write      <= 1'b1;
                end
                WR_REQ: begin
                    if (!avm_waitrequest) begin
                        state     <= DONE;
                        avm_write <= 1'b0;
                        HREADYExt <= 1'b1;
                    end
                end
                RD_REQ: begin
                    if (!avm_waitrequest) begin
                        state    <= RD_WAIT;
                        avm_read <= 1'b0;
                    end
                end
                RD_WAIT: begin
                    if (avm_readdatavalid) begin
                        state     <= DONE;
                        HRDATAExt <= avm_readdata;
                        HREADYExt <= 1'b1;
                    end
                end
                ERR1: begin
                    state     <= ERR2;
                    HREADYExt <= 1'b1;
                    HRESPExt  <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    HREADYExt <= 1'b1;
                    HRESPExt  <= 1'b0;
                    avm_read  <= 1'b0;
                    avm_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_avalon_extmem_bridge.sv
// Scoreboard bench: drivers push expected AHB/Avalon responses, two monitors pop and compare.
module tb_ahb_avalon_extmem_bridge;

    logic        clk;
    logic        reset;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic [3:0]  hwstrb;
    logic        hready_ext;
    logic        hresp_ext;
    logic [31:0] hrdata_ext;
    logic [27:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;

    ahb_avalon_extmem_bridge dut (
        .clk               (clk),
        .reset             (reset),
        .HSELExt           (hsel),
        .HADDR             (haddr),
        .HTRANS            (htrans),
        .HWRITE            (hwrite),
        .HSIZE             (hsize),
        .HBURST            (hburst),
        .HREADY            (hready_ext),
        .HWDATA            (hwdata),
        .HWSTRB            (hwstrb),
        .HREADYExt         (hready_ext),
        .HRESPExt          (hresp_ext),
        .HRDATAExt         (hrdata_ext),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_byteenable    (avm_byteenable),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid)
    );

    typedef struct {
        logic        resp;
        logic        chk_data;
        logic [31:0] rdata;
        int          due;
    } ahb_exp_t;

    typedef struct {
        logic        wr;
        logic [27:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        int          cycles;
    } avl_exp_t;

    ahb_exp_t    ahb_q[$];
    avl_exp_t    avl_q[$];
    int          checks;
    int          failures;
    int          cyc;
    logic        rst_seq;
    int          stall_cfg;
    int          lat_cfg;
    logic [31:0] rd_data_cfg;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Avalon slave: configurable waitrequest stall and fixed read latency from the accepted read.
    initial begin
        int  stall_left;
        int  rd_cnt;
        logic in_strobe;
        stall_left = 0;
        rd_cnt = 0;
        in_strobe = 1'b0;
        avm_waitrequest = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata = '0;
        forever begin
            @(negedge clk);
            avm_readdatavalid = 1'b0;
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata = rd_data_cfg;
                end
            end
            if (avm_read || avm_write) begin
                if (!in_strobe) begin
                    in_strobe = 1'b1;
                    stall_left = stall_cfg;
                end
                if (stall_left > 0) begin
                    avm_waitrequest = 1'b1;
                    stall_left--;
                end else begin
                    avm_waitrequest = 1'b0;
                    in_strobe = 1'b0;
                    if (avm_read) rd_cnt = lat_cfg;
                end
            end else begin
                avm_waitrequest = 1'b0;
                in_strobe = 1'b0;
            end
        end
    end

    // AHB monitor: every stalled transfer ends on a low-to-high HREADYExt transition.
    initial begin
        logic     prev_rdy;
        logic     prev_resp;
        ahb_exp_t e;
        prev_rdy = 1'b1;
        prev_resp = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_seq && hready_ext && !prev_rdy) begin
                if (ahb_q.size() == 0) begin
                    fail_now("ahb_unexpected_completion");
                end else begin
                    e = ahb_q.pop_front();
                    chk("ahb_resp", hresp_ext, e.resp);
                    chk("ahb_resp_first_cycle", prev_resp, e.resp);
                    if (e.chk_data) chk("ahb_rdata", hrdata_ext, e.rdata);
                    chk("ahb_done_cycle", cyc, e.due);
                end
            end
            prev_rdy = hready_ext;
            prev_resp = hresp_ext;
        end
    end

    // Avalon monitor: compares every strobe cycle against the head entry, pops on acceptance.
    initial begin
        int       held;
        avl_exp_t e;
        held = 0;
        forever begin
            @(negedge clk);
            #1;
            if (avm_read || avm_write) begin
                chk("avm_strobe_overlap", avm_read & avm_write, 0);
                if (avl_q.size() == 0) begin
                    fail_now("avm_unexpected_strobe");
                end else begin
                    e = avl_q[0];
                    held++;
                    chk("avm_write", avm_write, e.wr);
                    chk("avm_address", avm_address, e.addr);
                    chk("avm_byteenable", avm_byteenable, e.be);
                    if (e.wr) chk("avm_writedata", avm_writedata, e.data);
                    if (!avm_waitrequest) begin
                        chk("avm_hold_cycles", held, e.cycles);
                        held = 0;
                        void'(avl_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic exp_avl(input logic wr, input logic [27:0] addr, input logic [3:0] be,
                           input logic [31:0] data, input int cycles);
        avl_exp_t e;
        e.wr = wr; e.addr = addr; e.be = be; e.data = data; e.cycles = cycles;
        avl_q.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle where the data phase completes.
    task automatic ahb_xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                            input logic [31:0] wdata, input logic [3:0] strb,
                            input logic exp_resp, input logic exp_chk,
                            input logic [31:0] exp_rdata, input int exp_lat);
        int       guard;
        ahb_exp_t e;
        hsel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr; hsize = size;
        guard = 0;
        while (!hready_ext && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        if (guard >= 50) fail_now("addr_phase_timeout");
        e.resp = exp_resp; e.chk_data = exp_chk; e.rdata = exp_rdata; e.due = cyc + exp_lat;
        ahb_q.push_back(e);
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = wdata; hwstrb = strb;
        guard = 0;
        while (!hready_ext && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        if (guard >= 50) fail_now("data_phase_timeout");
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1; rst_seq = 1'b1;
        hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd2;
        hburst = 3'd0; hwdata = '0; hwstrb = '0;
        stall_cfg = 0; lat_cfg = 1; rd_data_cfg = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hready", hready_ext, 1);
        chk("rst_hresp", hresp_ext, 0);
        chk("rst_hrdata", hrdata_ext, 0);
        chk("rst_avm_read", avm_read, 0);
        chk("rst_avm_write", avm_write, 0);
        chk("rst_avm_address", avm_address, 0);
        chk("rst_avm_be", avm_byteenable, 0);
        chk("rst_avm_wdata", avm_writedata, 0);
        reset = 1'b0;
        idle_cycle();
        rst_seq = 1'b0;

        // Word write
        exp_avl(1'b1, 28'h10, 4'b1111, 32'hDEAD_BEEF, 1);
        ahb_xfer(32'h2000_0010, 1'b1, 3'd2, 32'hDEAD_BEEF, 4'b1111, 1'b0, 1'b0, 32'h0, 3);
        idle_cycle();

        // Byte read, read latency 2
        lat_cfg = 2; rd_data_cfg = 32'h1122_3344;
        exp_avl(1'b0, 28'h10, 4'b1000, 32'h0, 1);
        ahb_xfer(32'h2000_0013, 1'b0, 3'd0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h1122_3344, 4);
        idle_cycle();

        // Word read stalled by waitrequest for 3 cycles, latency 1
        stall_cfg = 3; lat_cfg = 1; rd_data_cfg = 32'hCAFE_F00D;
        exp_avl(1'b0, 28'h100, 4'b1111, 32'h0, 4);
        ahb_xfer(32'h2000_0100, 1'b0, 3'd2, 32'h0, 4'h0, 1'b0, 1'b1, 32'hCAFE_F00D, 6);
        stall_cfg = 0;
        idle_cycle();

        // Upper half-word read
        rd_data_cfg = 32'hA5A5_5A5A;
        exp_avl(1'b0, 28'h4, 4'b1100, 32'h0, 1);
        ahb_xfer(32'h2000_0006, 1'b0, 3'd1, 32'h0, 4'h0, 1'b0, 1'b1, 32'hA5A5_5A5A, 3);
        idle_cycle();

        // Back-to-back: partial write, then read issued in DONE
        rd_data_cfg = 32'h5566_7788;
        exp_avl(1'b1, 28'h0, 4'b0011, 32'h0102_0304, 1);
        exp_avl(1'b0, 28'h4, 4'b1111, 32'h0, 1);
        ahb_xfer(32'h2000_0000, 1'b1, 3'd2, 32'h0102_0304, 4'b0011, 1'b0, 1'b0, 32'h0, 3);
        ahb_xfer(32'h2000_0004, 1'b0, 3'd2, 32'h0, 4'h0, 1'b0, 1'b1, 32'h5566_7788, 3);
        idle_cycle();

        // Error chain, each next transfer issued in ERR2, ending with a legal byte write
        ahb_xfer(32'h2000_0002, 1'b0, 3'd2, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 2);
        ahb_xfer(32'h2000_0008, 1'b1, 3'd3, 32'h0, 4'hF, 1'b1, 1'b0, 32'h0, 2);
        ahb_xfer(32'h2000_0001, 1'b0, 3'd1, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 2);
        exp_avl(1'b1, 28'h8, 4'b0010, 32'h0000_AB00, 1);
        ahb_xfer(32'h2000_0009, 1'b1, 3'd0, 32'h0000_AB00, 4'b0010, 1'b0, 1'b0, 32'h0, 3);
        idle_cycle();

        // IDLE/BUSY while selected, and NONSEQ while deselected: zero-wait OKAY, no state change
        hsel = 1'b1; htrans = 2'b00; haddr = 32'h2000_0040; hwrite = 1'b0; hsize = 3'd2;
        idle_cycle();
        chk("idle_hready", hready_ext, 1);
        chk("idle_hresp", hresp_ext, 0);
        htrans = 2'b01;
        idle_cycle();
        chk("busy_hready", hready_ext, 1);
        chk("busy_no_read", avm_read, 0);
        hsel = 1'b0; htrans = 2'b10;
        idle_cycle();
        chk("desel_hready", hready_ext, 1);
        chk("desel_no_read", avm_read, 0);
        htrans = 2'b00;
        chk("hrdata_held", hrdata_ext, 32'h5566_7788);
        idle_cycle();

        // Reset while waiting for read data; the late return must be ignored
        lat_cfg = 3; rd_data_cfg = 32'hFEED_FACE;
        exp_avl(1'b0, 28'h20, 4'b1111, 32'h0, 1);
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h2000_0020; hwrite = 1'b0; hsize = 3'd2;
        idle_cycle();
        hsel = 1'b0; htrans = 2'b00;
        idle_cycle();
        chk("rdwait_hready", hready_ext, 0);
        rst_seq = 1'b1; reset = 1'b1;
        idle_cycle();
        reset = 1'b0;
        chk("mid_rst_hready", hready_ext, 1);
        chk("mid_rst_hresp", hresp_ext, 0);
        chk("mid_rst_hrdata", hrdata_ext, 0);
        chk("mid_rst_avm_read", avm_read, 0);
        chk("mid_rst_avm_address", avm_address, 0);
        chk("mid_rst_avm_be", avm_byteenable, 0);
        repeat (3) idle_cycle();
        chk("late_rdata_ignored", hrdata_ext, 0);
        chk("late_hready", hready_ext, 1);
        rst_seq = 1'b0;

        // Recovery read after reset
        lat_cfg = 1; rd_data_cfg = 32'h0BAD_C0DE;
        exp_avl(1'b0, 28'h20, 4'b1111, 32'h0, 1);
        ahb_xfer(32'h2000_0020, 1'b0, 3'd2, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0BAD_C0DE, 3);

        repeat (5) idle_cycle();
        chk("ahb_queue_drained", ahb_q.size(), 0);
        chk("avl_queue_drained", avl_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
